// File: rtl/m_wbgpio.sv
// Wishbone classic GPIO slave: NOUT outputs with atomic set/clear/toggle writes,
// NIN synchronised inputs with sticky rising-edge flags and a maskable interrupt.
module m_wbgpio #(
  parameter int              NOUT       = 8,
  parameter int              NIN        = 8,
  parameter int              SYNCSTAGES = 2,
  parameter logic [NOUT-1:0] OUTRESET   = '0
) (
  input  logic            CLK_I,
  input  logic            RST_I_n,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [2:0]      ADR_I,
  input  logic [3:0]      SEL_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  output logic            ACK_O,
  input  logic [NIN-1:0]  gpi,
  output logic [NOUT-1:0] gpo,
  output logic            irq
);

  localparam int              PW         = $clog2(SYNCSTAGES + 2);
  localparam logic [PW-1:0]   PRIME_DONE = PW'(SYNCSTAGES + 1);

  typedef enum logic [2:0] {
    A_OUT    = 3'd0,
    A_OUTSET = 3'd1,
    A_OUTCLR = 3'd2,
    A_OUTTGL = 3'd3,
    A_IN     = 3'd4,
    A_EDGE   = 3'd5,
    A_IRQEN  = 3'd6,
    A_NONE   = 3'd7
  } reg_addr_e;

  reg_addr_e       addr;
  logic            req;
  logic            wr;
  logic [31:0]     lane_mask;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [NOUT-1:0] gpo_d;
  logic [NIN-1:0]  irqen;
  logic [NIN-1:0]  irqen_d;
  logic [NIN-1:0]  edge_q;
  logic [NIN-1:0]  w1c;
  logic [NIN-1:0]  sync_q [SYNCSTAGES];
  logic [NIN-1:0]  s;
  logic [NIN-1:0]  prev;
  logic [NIN-1:0]  rise;
  logic [PW-1:0]   prime_cnt;
  logic            primed;
  logic            unused_wdata;

  assign addr      = reg_addr_e'(ADR_I);
  assign req       = CYC_I & STB_I & ~ACK_O;
  assign wr        = req & WE_I;
  assign lane_mask = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
  assign wdata     = DAT_I & lane_mask;
  // Data bits above NOUT/NIN are deliberately dropped.
  assign unused_wdata = ^wdata;

  assign s      = sync_q[SYNCSTAGES-1];
  assign primed = (prime_cnt == PRIME_DONE);
  // Until prev holds a real sample, a pin high at reset would look like a rise.
  assign rise   = s & ~prev & {NIN{primed}};

  // Write side effects; unselected byte lanes keep their value for OUT/IRQEN.
  always_comb begin
    gpo_d   = gpo;
    irqen_d = irqen;
    w1c     = '0;
    if (wr) begin
      case (addr)
        A_OUT:    gpo_d   = (gpo & ~lane_mask[NOUT-1:0]) | wdata[NOUT-1:0];
        A_OUTSET: gpo_d   = gpo | wdata[NOUT-1:0];
        A_OUTCLR: gpo_d   = gpo & ~wdata[NOUT-1:0];
        A_OUTTGL: gpo_d   = gpo ^ wdata[NOUT-1:0];
        A_EDGE:   w1c     = wdata[NIN-1:0];
        A_IRQEN:  irqen_d = (irqen & ~lane_mask[NIN-1:0]) | wdata[NIN-1:0];
        default:  ;
      endcase
    end
  end

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    rdata = '0;
    case (addr)
      A_OUT, A_OUTSET, A_OUTCLR, A_OUTTGL: rdata[NOUT-1:0] = gpo;
      A_IN:    rdata[NIN-1:0] = s;
      A_EDGE:  rdata[NIN-1:0] = edge_q;
      A_IRQEN: rdata[NIN-1:0] = irqen;
      default: rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK_I or negedge RST_I_n) begin
    if (!RST_I_n) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
      gpo   <= OUTRESET;
      irqen <= '0;
      edge_q <= '0;
      irq   <= 1'b0;
    end else begin
      ACK_O  <= req;
      DAT_O  <= (req & ~WE_I) ? rdata : '0;
      gpo    <= gpo_d;
      irqen  <= irqen_d;
      // Set wins over a simultaneous write-1-to-clear.
      edge_q <= (edge_q & ~w1c) | rise;
      irq    <= |(edge_q & irqen);
    end
  end

  // NOTE: the synchroniser array is a handful of flops, not a RAM, so it is
  // reset like any other state.
  always_ff @(posedge CLK_I or negedge RST_I_n) begin
    if (!RST_I_n) begin
      for (int i = 0; i < SYNCSTAGES; i++) sync_q[i] <= '0;
      prev      <= '0;
      prime_cnt <= '0;
    end else begin
      sync_q[0] <= gpi;
      for (int i = 1; i < SYNCSTAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= s;
      if (!primed) prime_cnt <= prime_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_m_wbgpio.sv
// Self-checking bench for m_wbgpio: directed handshake/edge/irq steps plus
// randomized register traffic checked against a register-level model.
module tb_m_wbgpio;

  logic        CLK_I = 1'b0;
  logic        RST_I_n = 1'b0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I = 1'b0;
  logic [2:0]  ADR_I = '0;
  logic [3:0]  SEL_I = '0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic [7:0]  gpi = 8'hFF;
  logic [31:0] gpo;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  // Register-level model
  logic [31:0] m_gpo   = 32'h0000_00A5;
  logic [7:0]  m_in    = 8'hFF;
  logic [7:0]  m_edge  = 8'h00;
  logic [7:0]  m_irqen = 8'h00;

  m_wbgpio #(
    .NOUT(32), .NIN(8), .SYNCSTAGES(2), .OUTRESET(32'h0000_00A5)
  ) dut (
    .CLK_I(CLK_I), .RST_I_n(RST_I_n), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ADR_I(ADR_I), .SEL_I(SEL_I), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK_O(ACK_O), .gpi(gpi), .gpo(gpo), .irq(irq)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic void model_write(input logic [2:0] adr, input logic [3:0] sel,
                                      input logic [31:0] dat);
    logic [31:0] m;
    logic [31:0] d;
    m = lanes(sel);
    d = dat & m;
    case (adr)
      3'd0: m_gpo = (m_gpo & ~m) | d;
      3'd1: m_gpo = m_gpo | d;
      3'd2: m_gpo = m_gpo & ~d;
      3'd3: m_gpo = m_gpo ^ d;
      3'd5: m_edge = m_edge & ~d[7:0];
      3'd6: m_irqen = (m_irqen & ~m[7:0]) | d[7:0];
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] adr);
    case (adr)
      3'd0, 3'd1, 3'd2, 3'd3: return m_gpo;
      3'd4: return {24'h0, m_in};
      3'd5: return {24'h0, m_edge};
      3'd6: return {24'h0, m_irqen};
      default: return 32'h0;
    endcase
  endfunction

  // One complete access; ACK must appear on the first edge and last one cycle.
  task automatic wb(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                    input logic [31:0] dat, output logic [31:0] rd, output logic irq_ack);
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; SEL_I = sel; DAT_I = dat;
    @(posedge CLK_I); #1;
    check("ack_high", 32'(ACK_O), 32'd1);
    rd = DAT_O;
    irq_ack = irq;
    if (we) check("dat_o_on_write", DAT_O, 32'h0);
    @(negedge CLK_I);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(posedge CLK_I); #1;
    check("ack_low", 32'(ACK_O), 32'd0);
    check("dat_o_idle", DAT_O, 32'h0);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] rd;
    logic        ia;
    wb(1'b1, adr, sel, dat, rd, ia);
    model_write(adr, sel, dat);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] adr);
    logic [31:0] rd;
    logic        ia;
    wb(1'b0, adr, 4'h0, 32'h0, rd, ia);
    check(tag, rd, model_read(adr));
  endtask

  // Change the pins and wait long enough for the synchroniser and edge logic.
  task automatic settle(input logic [7:0] v);
    @(negedge CLK_I);
    gpi = v;
    repeat (6) @(posedge CLK_I);
    #1;
    m_edge = m_edge | (v & ~m_in);
    m_in   = v;
  endtask

  initial begin
    logic [31:0] rd;
    logic        ia;
    logic [2:0]  a;
    logic [3:0]  sl;
    logic [31:0] dv;

    // Reset with pins already high
    repeat (2) @(posedge CLK_I);
    #1;
    check("rst_gpo", gpo, 32'h0000_00A5);
    check("rst_ack", 32'(ACK_O), 32'd0);
    check("rst_dat_o", DAT_O, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge CLK_I);
    RST_I_n = 1'b1;
    repeat (10) @(posedge CLK_I);
    #1;
    rd_chk("rst_edge_zero", 3'd5);
    rd_chk("rst_in_ff", 3'd4);

    // Atomic output operations
    wr(3'd0, 4'hF, 32'h0000_000F); rd_chk("out_write", 3'd0);
    check("out_gpo", gpo, 32'h0000_000F);
    wr(3'd1, 4'hF, 32'h0000_0030); rd_chk("outset", 3'd1);
    check("outset_gpo", gpo, 32'h0000_003F);
    wr(3'd2, 4'hF, 32'h0000_0003); rd_chk("outclr", 3'd2);
    check("outclr_gpo", gpo, 32'h0000_003C);
    wr(3'd3, 4'hF, 32'h0000_00FF); rd_chk("outtgl", 3'd3);
    check("outtgl_gpo", gpo, 32'h0000_00C3);

    // Byte-lane masked full write
    wr(3'd0, 4'hF, 32'h0);
    wr(3'd0, 4'h1, 32'h1234_5678);
    check("sel_lane0_gpo", gpo, 32'h0000_0078);
    rd_chk("sel_lane0_read", 3'd0);

    // Edge detect latency and irq
    settle(8'hFE);
    rd_chk("fall_no_edge", 3'd5);
    wr(3'd6, 4'hF, 32'h0000_0001);
    @(negedge CLK_I);
    gpi = 8'hFF;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK_I); #1;
      check($sformatf("irq_latency_%0d", i), 32'(irq), 32'(i == 4));
    end
    m_edge = m_edge | 8'h01;
    m_in   = 8'hFF;
    rd_chk("edge0_set", 3'd5);
    wb(1'b1, 3'd5, 4'hF, 32'h0000_0001, rd, ia);
    model_write(3'd5, 4'hF, 32'h0000_0001);
    check("irq_in_ack_cycle", 32'(ia), 32'd1);
    check("irq_cleared", 32'(irq), 32'd0);

    // Rise coinciding with write-1-to-clear: set wins
    settle(8'hFE);
    @(negedge CLK_I);
    gpi = 8'hFF;
    @(posedge CLK_I);
    @(posedge CLK_I);
    wb(1'b1, 3'd5, 4'hF, 32'h0000_0001, rd, ia);
    m_in   = 8'hFF;
    m_edge = m_edge | 8'h01;
    rd_chk("set_wins", 3'd5);
    check("set_wins_irq", 32'(irq), 32'd1);
    wr(3'd5, 4'hF, 32'h0000_00FF);

    // Back-to-back reads with strobe held
    settle(8'h5A);
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 3'd4;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK_I); #1;
      check($sformatf("held_ack_%0d", i), 32'(ACK_O), 32'(i % 2 == 0));
      check($sformatf("held_dat_%0d", i), DAT_O, (i % 2 == 0) ? {24'h0, m_in} : 32'h0);
    end
    @(negedge CLK_I);
    CYC_I = 1'b0; STB_I = 1'b0;
    @(posedge CLK_I); #1;

    // Randomized register traffic
    for (int it = 0; it < 80; it++) begin
      a  = 3'($urandom_range(0, 7));
      sl = 4'($urandom_range(0, 15));
      dv = $urandom;
      case ($urandom_range(0, 3))
        0: wr(a, sl, dv);
        1: rd_chk($sformatf("rand_read_a%0d", a), a);
        2: settle(8'($urandom));
        default: wr(3'd5, sl, dv);
      endcase
      check("rand_gpo", gpo, m_gpo);
      check("rand_irq", 32'(irq), 32'(|(m_edge & m_irqen)));
    end
    rd_chk("rand_final_edge", 3'd5);
    rd_chk("rand_final_irqen", 3'd6);

    // Reset during a request
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 3'd0; SEL_I = 4'hF;
    DAT_I = 32'hDEAD_BEEF;
    #2 RST_I_n = 1'b0;
    @(posedge CLK_I); #1;
    check("midrst_ack", 32'(ACK_O), 32'd0);
    check("midrst_gpo", gpo, 32'h0000_00A5);
    check("midrst_irq", 32'(irq), 32'd0);
    @(negedge CLK_I);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    RST_I_n = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    check("midrst_no_late_ack", 32'(ACK_O), 32'd0);
    check("midrst_gpo_hold", gpo, 32'h0000_00A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
